// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/arith/shift ops plus an optional iterative
// multiply/divide unit (enabled by defining ALU_MULDIV_EN) with a Start/Busy/Done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   ShiftCount,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SGT   = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SRL   = 4'b1101;
    localparam logic [3:0] OP_SLL   = 4'b1110;
    localparam logic [3:0] OP_SRA   = 4'b1111;

    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             zero_reg;
    logic             overflow_reg;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_bits[gi] = A[gi] & B[gi];
            assign or_bits[gi]  = A[gi] | B[gi];
        end
    endgenerate

    always_comb begin
        sum       = A + B;
        diff      = A - B;
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (Op)
            OP_AND: sc_result = and_bits;
            OP_OR:  sc_result = or_bits;
            OP_NOR: sc_result = ~or_bits;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // A - B overflows when A and -B share a sign that the result lacks
                sc_result = diff;
                sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SGT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
            OP_SRL: sc_result = A >> ShiftCount;
            OP_SLL: sc_result = A << ShiftCount;
            OP_SRA: sc_result = $unsigned($signed(A) >>> ShiftCount);
            default: begin
                sc_result = '0;
                sc_ovf    = 1'b0;
            end
        endcase
    end

`ifdef ALU_MULDIV_EN
    // ---------------- iterative multiply / divide ----------------
    typedef enum logic [0:0] {IDLE, CALC} state_t;

    localparam logic [SHW-1:0]   LAST_ITER = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg;
    logic             busy_reg;
    logic [SHW-1:0]   count_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] a_reg;
    logic             is_div_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div0_reg;
    logic             minneg_reg;

    logic             is_muldiv;
    logic             is_div;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign is_muldiv = is_div || (Op == OP_MULT) || (Op == OP_MULTU);
    assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
    assign a_neg     = signed_op & A[WIDTH-1];
    assign b_neg     = signed_op & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   iter_hi;
    logic [WIDTH-1:0]   iter_lo;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   fin_hi;
    logic               fin_ovf;

    // hi_reg is the accumulator / partial remainder, lo_reg the multiplier / dividend-quotient
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_reg});
        div_diff  = div_shift[WIDTH-1:0] - mcand_reg;
        if (is_div_reg) begin
            iter_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            iter_lo = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_mag = {iter_hi, iter_lo};
        prod     = neg_q_reg ? -prod_mag : prod_mag;
        fin_res  = prod[WIDTH-1:0];
        fin_hi   = prod[2*WIDTH-1:WIDTH];
        fin_ovf  = 1'b0;
        if (is_div_reg) begin
            fin_res = neg_q_reg ? -iter_lo : iter_lo;
            fin_hi  = neg_r_reg ? -iter_hi : iter_hi;
            fin_ovf = minneg_reg;
            if (div0_reg) begin
                fin_res = '1;
                fin_hi  = a_reg;
                fin_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            count_reg     <= '0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        if (is_muldiv) begin
                            hi_reg     <= '0;
                            lo_reg     <= a_mag;
                            mcand_reg  <= b_mag;
                            a_reg      <= A;
                            is_div_reg <= is_div;
                            neg_q_reg  <= a_neg ^ b_neg;
                            neg_r_reg  <= a_neg;
                            div0_reg   <= is_div && (B == '0);
                            minneg_reg <= (Op == OP_DIV) && (A == MIN_VAL) && (B == '1);
                            count_reg  <= '0;
                            busy_reg   <= 1'b1;
                            state_reg  <= CALC;
                        end else begin
                            result_reg    <= sc_result;
                            result_hi_reg <= '0;
                            overflow_reg  <= sc_ovf;
                            zero_reg      <= (sc_result == '0);
                            done_reg      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    hi_reg    <= iter_hi;
                    lo_reg    <= iter_lo;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_ITER) begin
                        result_reg    <= fin_res;
                        result_hi_reg <= fin_hi;
                        overflow_reg  <= fin_ovf;
                        zero_reg      <= (fin_res == '0);
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Busy = busy_reg;
`else
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            done_reg      <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            if (Start) begin
                result_reg    <= sc_result;
                result_hi_reg <= '0;
                overflow_reg  <= sc_ovf;
                zero_reg      <= (sc_result == '0);
                done_reg      <= 1'b1;
            end
        end
    end

    assign Busy = 1'b0;
`endif

    assign Done     = done_reg;
    assign Result   = result_reg;
    assign ResultHi = result_hi_reg;
    assign Zero     = zero_reg;
    assign Overflow = overflow_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner steps plus random ops
// checked against an arithmetic reference model; follows ALU_MULDIV_EN if defined.
module tb_seq_alu;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ShiftCount;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] ResultHi;
    logic        Zero;
    logic        Overflow;

    int checks   = 0;
    int failures = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
        logic        multi;
    } exp_t;

    seq_alu #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .ShiftCount(ShiftCount), .Busy(Busy), .Done(Done), .Result(Result),
        .ResultHi(ResultHi), .Zero(Zero), .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        e = '0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                s = longint'(int'(a)) + longint'(int'(b));
                e.res = s[31:0];
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'b0110: begin
                s = longint'(int'(a)) - longint'(int'(b));
                e.res = s[31:0];
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'b0111: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b1000: e.res = (int'(a) > int'(b)) ? 32'd1 : 32'd0;
            4'b1101: e.res = a >> sh;
            4'b1110: e.res = a << sh;
            4'b1111: begin
                s = longint'(int'(a)) >>> sh;
                e.res = s[31:0];
            end
`ifdef ALU_MULDIV_EN
            4'b0011: begin
                s = longint'(int'(a)) * longint'(int'(b));
                {e.hi, e.res} = s;
                e.multi = 1'b1;
            end
            4'b0100: begin
                p = {32'd0, a} * {32'd0, b};
                {e.hi, e.res} = p;
                e.multi = 1'b1;
            end
            4'b0101: begin
                e.multi = 1'b1;
                if (b == 32'd0) begin
                    e.res = 32'hFFFFFFFF; e.hi = a; e.ovf = 1'b1;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.res = 32'h80000000; e.hi = 32'd0; e.ovf = 1'b1;
                end else begin
                    e.res = 32'(int'(a) / int'(b));
                    e.hi  = 32'(int'(a) % int'(b));
                end
            end
            4'b1001: begin
                e.multi = 1'b1;
                if (b == 32'd0) begin
                    e.res = 32'hFFFFFFFF; e.hi = a; e.ovf = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                end
            end
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'd1;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from idle, wait for Done, check outputs and the one-cycle pulse.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        int   cyc;
        e = model(op, a, b, sh);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b; ShiftCount = sh;
        @(negedge Clk);
        Start = 1'b0; Op = 4'($urandom); A = $urandom; B = $urandom; ShiftCount = 5'($urandom);
        check({tag, ".busy"}, 64'(Busy), 64'(e.multi));
        cyc = 0;
        while (Done !== 1'b1 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), e.multi ? 64'd32 : 64'd0);
        check({tag, ".result"}, 64'(Result), 64'(e.res));
        check({tag, ".hi"}, 64'(ResultHi), 64'(e.hi));
        check({tag, ".ovf"}, 64'(Overflow), 64'(e.ovf));
        check({tag, ".zero"}, 64'(Zero), 64'(e.res == 32'd0));
        $display("op=%b a=%h b=%h sh=%0d res=%h hi=%h ovf=%b cyc=%0d",
                 op, a, b, sh, Result, ResultHi, Overflow, cyc);
        @(negedge Clk);
        check({tag, ".done_pulse"}, 64'(Done), 64'd0);
        check({tag, ".busy_end"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int          cyc;
        logic        seen;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rsh;

        Rst_n = 1'b0; Start = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0; ShiftCount = 5'd0;
        repeat (3) @(negedge Clk);
        check("reset.busy", 64'(Busy), 64'd0);
        check("reset.done", 64'(Done), 64'd0);
        check("reset.result", 64'(Result), 64'd0);
        check("reset.hi", 64'(ResultHi), 64'd0);
        check("reset.ovf", 64'(Overflow), 64'd0);
        check("reset.zero", 64'(Zero), 64'd1);
        Rst_n = 1'b1;

        run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0);
        run_op("sub_ovf", 4'b0110, 32'h80000000, 32'd1, 5'd0);
        run_op("sub_zero", 4'b0110, 32'd1234, 32'd1234, 5'd0);
        run_op("slt", 4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0);
        run_op("sgt", 4'b1000, 32'hFFFFFFFF, 32'd1, 5'd0);
        run_op("sra", 4'b1111, 32'h80000000, 32'd0, 5'd4);
        run_op("srl", 4'b1101, 32'h80000000, 32'd0, 5'd4);
        run_op("nor", 4'b1100, 32'h0F0F0000, 32'h00FF00FF, 5'd0);
        run_op("undef", 4'b1010, 32'h12345678, 32'h9ABCDEF0, 5'd3);
        run_op("mult", 4'b0011, 32'hFFFFFFFD, 32'd7, 5'd0);
        run_op("mult5", 4'b0011, 32'd5, 32'd5, 5'd0);
        run_op("div", 4'b0101, 32'hFFFFFFF9, 32'd2, 5'd0);
        run_op("divu0", 4'b1001, 32'd7, 32'd0, 5'd0);
        run_op("div_minneg", 4'b0101, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        run_op("multu", 4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);

        // Back-to-back single-cycle ops: Start held for two edges.
        @(negedge Clk);
        Start = 1'b1; Op = 4'b0010; A = 32'd10; B = 32'd20; ShiftCount = 5'd0;
        @(negedge Clk);
        check("b2b.first", 64'(Result), 64'd30);
        check("b2b.first_done", 64'(Done), 64'd1);
        Op = 4'b1110; A = 32'h00000003; ShiftCount = 5'd30;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b.second", 64'(Result), 64'hC0000000);
        check("b2b.second_done", 64'(Done), 64'd1);
        @(negedge Clk);
        check("b2b.done_low", 64'(Done), 64'd0);

`ifdef ALU_MULDIV_EN
        // Start while busy is ignored; SRA issued in the Done cycle is accepted.
        @(negedge Clk);
        Start = 1'b1; Op = 4'b1001; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0; cyc = 0;
        repeat (5) begin @(negedge Clk); cyc++; end
        Start = 1'b1; Op = 4'b0110; A = 32'd1; B = 32'd2;
        @(negedge Clk);
        cyc++;
        Start = 1'b0;
        while (Done !== 1'b1 && cyc < 100) begin
            @(negedge Clk);
            cyc++;
        end
        check("busy_ign.latency", 64'(cyc), 64'd32);
        check("busy_ign.quot", 64'(Result), 64'd14);
        check("busy_ign.rem", 64'(ResultHi), 64'd2);
        Start = 1'b1; Op = 4'b1111; A = 32'h80000000; ShiftCount = 5'd4;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b_sra.done", 64'(Done), 64'd1);
        check("b2b_sra.result", 64'(Result), 64'hF8000000);
        check("b2b_sra.hi", 64'(ResultHi), 64'd0);
        $display("op=1111 back-to-back after divu res=%h", Result);

        // Reset at edge k+10 aborts a MULT with no Done.
        @(negedge Clk);
        Start = 1'b1; Op = 4'b0011; A = 32'd9; B = 32'd11;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        check("abort.busy", 64'(Busy), 64'd0);
        check("abort.result", 64'(Result), 64'd0);
        check("abort.zero", 64'(Zero), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1) seen = 1'b1;
        end
        check("abort.no_done", 64'(seen), 64'd0);
        $display("reset abort of mult done_seen=%b", seen);
`endif

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = pick();
            rb  = pick();
            rsh = 5'($urandom);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, rsh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
